// File: rtl/srio_pkg.sv
// srio_pkg
//   Shared definitions for the SRIO ireq arbiter slice: FSM state encoding,
//   ireq AXI-Stream field widths, the default packet length limit and the
//   FTYPE codes used by requesters when building headers.
//   Also provides a small one-hot to index helper used by the arbiter.

package srio_pkg;

  // Arbiter FSM: ARB_s picks an owner, XFER_s forwards that owner's packet.
  typedef enum logic {
    ARB_s  = 1'b0,
    XFER_s = 1'b1
  } arbState_e;

  localparam int IREQ_DATA_W       = 64;
  localparam int IREQ_KEEP_W       = 8;
  localparam int IREQ_USER_W       = 32;

  // One header beat plus 32 data beats (256 B payload).
  localparam int DEFAULT_MAX_BEATS = 33;

  localparam logic [3:0] FTYPE_DOORB = 4'hA;
  localparam logic [3:0] FTYPE_NWR   = 4'h5;

  // Converts a one-hot vector (up to 8 requesters) into its bit index.
  // An all-zero input maps to index 0.
  function automatic logic [2:0] oneHotToIdx(input logic [7:0] oneHot);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oneHot[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/srio_ireq_arbiter_if.sv
// srio_ireq_arbiter_if
//   Bundles the requester-side AXI-Stream ports and the single core-side
//   ireq AXI-Stream channel of the arbiter.
//   Requester side (packed, requester i at slice i):
//     s_tvalid/s_tready/s_tlast [NUM_REQ], s_tdata [64*NUM_REQ],
//     s_tkeep [8*NUM_REQ], s_tuser [32*NUM_REQ] ({src_id, dest_id})
//   Core side:
//     ireq_tvalid_o, ireq_tready_in, ireq_tlast_o, ireq_tdata_o,
//     ireq_tkeep_o, ireq_tuser_o
//   Modports:
//     master - drives requests and core ready (requesters + core model)
//     slave  - the arbiter itself

interface srio_ireq_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import srio_pkg::*;

  logic [NUM_REQ-1:0]             s_tvalid;
  logic [NUM_REQ-1:0]             s_tready;
  logic [NUM_REQ-1:0]             s_tlast;
  logic [IREQ_DATA_W*NUM_REQ-1:0] s_tdata;
  logic [IREQ_KEEP_W*NUM_REQ-1:0] s_tkeep;
  logic [IREQ_USER_W*NUM_REQ-1:0] s_tuser;

  logic                   ireq_tvalid_o;
  logic                   ireq_tready_in;
  logic                   ireq_tlast_o;
  logic [IREQ_DATA_W-1:0] ireq_tdata_o;
  logic [IREQ_KEEP_W-1:0] ireq_tkeep_o;
  logic [IREQ_USER_W-1:0] ireq_tuser_o;

  modport master (
    output s_tvalid, s_tlast, s_tdata, s_tkeep, s_tuser,
    input  s_tready,
    input  ireq_tvalid_o, ireq_tlast_o, ireq_tdata_o, ireq_tkeep_o, ireq_tuser_o,
    output ireq_tready_in
  );

  modport slave (
    input  s_tvalid, s_tlast, s_tdata, s_tkeep, s_tuser,
    output s_tready,
    output ireq_tvalid_o, ireq_tlast_o, ireq_tdata_o, ireq_tkeep_o, ireq_tuser_o,
    input  ireq_tready_in
  );

endinterface

// File: rtl/srio_ireq_arbiter_rr_pick.sv
// srio_rr_pick
//   Combinational rotate-priority picker. Returns a one-hot grant for the
//   first asserted request found searching upward from ptr_i, wrapping
//   around at NUM_REQ-1.
//   Ports:
//     req_i   [NUM_REQ] request vector
//     ptr_i   [PTR_W]   index with highest priority this cycle
//     grant_o [NUM_REQ] one-hot pick, all zero when no request

module srio_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  int               sum;
  logic [PTR_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester at or
  // above the pointer is the one left standing in grant_o.
  always_comb begin
    grant_o = '0;
    sum     = 0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = int'(ptr_i) + k;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      idx = PTR_W'(sum);
      if (req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/srio_ireq_arbiter.sv
// srio_ireq_arbiter
//   Packet-granular arbiter sharing the SRIO logical-layer ireq channel
//   between NUM_REQ requesters. One owner at a time, the grant is held until
//   the owner's tlast handshake, then ownership rotates round-robin with a
//   one-cycle bubble between packets.
//   Ports:
//     log_clk, log_rst : clock, synchronous active-high reset
//     bus              : srio_ireq_arbiter_if.slave (requester + core streams)
//     grant_o          : one-hot current owner, 0 when idle
//     busy_o           : a packet is in flight
//     overlong_o       : one-cycle pulse when a packet runs past MAX_BEATS
//   Build option:
//     SRIO_IREQ_ARB_DB_PRIO_EN - requester 0 (doorbell path) gets strict
//     priority at arbitration and its packets do not advance the pointer.

module srio_ireq_arbiter
  import srio_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BEATS = DEFAULT_MAX_BEATS
) (
  input  logic                 log_clk,
  input  logic                 log_rst,
  srio_ireq_arbiter_if.slave   bus,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 overlong_o
);

  localparam int               PTR_W       = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_REQ - 1);
  localparam logic [5:0]       OVERLONG_AT = 6'(MAX_BEATS - 1);

  arbState_e        state_q;
  logic [PTR_W-1:0] rrPtr_q;
  logic [PTR_W-1:0] gIdx_q;
  logic [5:0]       beatCnt_q;
  logic [5:0]       beatCnt_d;
  logic [PTR_W-1:0] rrPtr_d;

  logic [NUM_REQ-1:0] pickReq;
  logic [NUM_REQ-1:0] rrPick;
  logic [NUM_REQ-1:0] pick;
  logic               beatXfer;
  logic               beatLast;

  logic [IREQ_DATA_W-1:0] reqData [NUM_REQ];
  logic [IREQ_KEEP_W-1:0] reqKeep [NUM_REQ];
  logic [IREQ_USER_W-1:0] reqUser [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign reqData[i] = bus.s_tdata[i*IREQ_DATA_W +: IREQ_DATA_W];
    assign reqKeep[i] = bus.s_tkeep[i*IREQ_KEEP_W +: IREQ_KEEP_W];
    assign reqUser[i] = bus.s_tuser[i*IREQ_USER_W +: IREQ_USER_W];
  end

`ifdef SRIO_IREQ_ARB_DB_PRIO_EN
  // Port 0 bypasses the rotation; the rest rotate among themselves.
  assign pickReq = {bus.s_tvalid[NUM_REQ-1:1], 1'b0};
  assign pick    = bus.s_tvalid[0] ? NUM_REQ'(1) : rrPick;
`else
  assign pickReq = bus.s_tvalid;
  assign pick    = rrPick;
`endif

  srio_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req_i   (pickReq),
    .ptr_i   (rrPtr_q),
    .grant_o (rrPick)
  );

  assign beatXfer  = (state_q == XFER_s) && bus.s_tvalid[gIdx_q] && bus.ireq_tready_in;
  assign beatLast  = bus.s_tlast[gIdx_q];
  assign beatCnt_d = (beatCnt_q == 6'd63) ? beatCnt_q : beatCnt_q + 6'd1;
  assign rrPtr_d   = (gIdx_q == LAST_IDX) ? '0 : gIdx_q + PTR_W'(1);

  // Zero-latency path from the owner to the core. Payload fields follow
  // the last owner even when idle; only valid, last and ready are gated.
  always_comb begin
    bus.s_tready      = '0;
    bus.ireq_tvalid_o = 1'b0;
    bus.ireq_tlast_o  = 1'b0;
    bus.ireq_tdata_o  = reqData[gIdx_q];
    bus.ireq_tkeep_o  = reqKeep[gIdx_q];
    bus.ireq_tuser_o  = reqUser[gIdx_q];
    if (state_q == XFER_s) begin
      bus.ireq_tvalid_o    = bus.s_tvalid[gIdx_q];
      bus.ireq_tlast_o     = bus.s_tlast[gIdx_q];
      bus.s_tready[gIdx_q] = bus.ireq_tready_in;
    end
  end

  // Arbitration / transfer FSM with registered grant, busy and overlong.
  // The overlong pulse flags the packet but never truncates it.
  always_ff @(posedge log_clk) begin
    if (log_rst) begin
      state_q    <= ARB_s;
      rrPtr_q    <= '0;
      gIdx_q     <= '0;
      beatCnt_q  <= '0;
      grant_o    <= '0;
      busy_o     <= 1'b0;
      overlong_o <= 1'b0;
    end else begin
      overlong_o <= 1'b0;
      case (state_q)
        ARB_s: begin
          if (|bus.s_tvalid) begin
            grant_o <= pick;
            gIdx_q  <= PTR_W'(oneHotToIdx(8'(pick)));
            busy_o  <= 1'b1;
            state_q <= XFER_s;
          end
        end
        XFER_s: begin
          if (beatXfer) begin
            if (beatLast) begin
`ifdef SRIO_IREQ_ARB_DB_PRIO_EN
              if (gIdx_q != '0) begin
                rrPtr_q <= rrPtr_d;
              end
`else
              rrPtr_q <= rrPtr_d;
`endif
              grant_o   <= '0;
              busy_o    <= 1'b0;
              beatCnt_q <= '0;
              state_q   <= ARB_s;
            end else begin
              if (beatCnt_q == OVERLONG_AT) begin
                overlong_o <= 1'b1;
              end
              beatCnt_q <= beatCnt_d;
            end
          end
        end
        default: state_q <= ARB_s;
      endcase
    end
  end

endmodule

// File: tb/tb_srio_ireq_arbiter.sv
// tb_srio_ireq_arbiter
//   Drives packet queues into each requester port and a core ready pattern,
//   and compares every cycle against a packet-level reference model of the
//   arbitration rules (owner, pointer, beat count, overlong).

module tb_srio_ireq_arbiter;
  import srio_pkg::*;

  localparam int NUM_REQ   = 2;
  localparam int MAX_BEATS = 33;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [31:0] user;
    logic        last;
  } beat_t;

  logic               log_clk = 1'b0;
  logic               log_rst = 1'b1;
  logic [NUM_REQ-1:0] grant_o;
  logic               busy_o;
  logic               overlong_o;

  srio_ireq_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  srio_ireq_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .log_clk    (log_clk),
    .log_rst    (log_rst),
    .bus        (bus),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .overlong_o (overlong_o)
  );

  always #5 log_clk = ~log_clk;

  beat_t              portQ [NUM_REQ][$];
  logic [NUM_REQ-1:0] grantLog [$];
  int                 readyPat [$];
  int                 checks = 0;
  int                 errors = 0;
  int                 ovlSeen = 0;
  int                 beatsSeen = 0;
  bit                 holdValid = 1'b1;
  bit                 holdReady = 1'b1;
  bit                 rstReq = 1'b1;
  logic [NUM_REQ-1:0] prevGrant = '0;

  // Reference model state: owner index (-1 idle), pointer, beat count.
  int mOwner = -1;
  int mPtr   = 0;
  int mCnt   = 0;
  bit mOvl   = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int modelPick(input logic [NUM_REQ-1:0] v);
`ifdef SRIO_IREQ_ARB_DB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (mPtr + k) % NUM_REQ;
`ifdef SRIO_IREQ_ARB_DB_PRIO_EN
      if (idx == 0) continue;
`endif
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit modelIdle();
    bit idle;
    idle = (mOwner < 0);
    for (int p = 0; p < NUM_REQ; p++) begin
      if (portQ[p].size() != 0) idle = 1'b0;
    end
    return idle;
  endfunction

  task automatic enqueuePacket(input int port, input int nBeats,
                               input bit useFirst, input logic [63:0] firstData);
    beat_t b;
    logic [31:0] user;
    user = $urandom;
    for (int i = 0; i < nBeats; i++) begin
      b.data = {$urandom, $urandom};
      if (i == 0) begin
        b.data[59:56] = (port == 0) ? FTYPE_DOORB : FTYPE_NWR;
        if (useFirst) b.data = firstData;
      end
      b.keep = (i == nBeats - 1) ? 8'($urandom) : 8'hFF;
      b.user = user;
      b.last = (i == nBeats - 1);
      portQ[port].push_back(b);
    end
  endtask

  // One clock: drive at negedge, check just after, then advance the model
  // by what the coming posedge will do with these inputs.
  task automatic applyStimulus();
    logic [NUM_REQ-1:0] expReady;
    bit                 expValid;
    beat_t              hb;
    @(negedge log_clk);
    log_rst = rstReq;
    for (int p = 0; p < NUM_REQ; p++) begin
      if (portQ[p].size() > 0 && (holdValid || $urandom_range(0, 3) != 0)) begin
        hb = portQ[p][0];
        bus.s_tvalid[p] = 1'b1;
        bus.s_tlast[p]  = hb.last;
        bus.s_tdata[p*64 +: 64] = hb.data;
        bus.s_tkeep[p*8 +: 8]   = hb.keep;
        bus.s_tuser[p*32 +: 32] = hb.user;
      end else begin
        bus.s_tvalid[p] = 1'b0;
        bus.s_tlast[p]  = 1'($urandom);
        bus.s_tdata[p*64 +: 64] = {$urandom, $urandom};
        bus.s_tkeep[p*8 +: 8]   = 8'($urandom);
        bus.s_tuser[p*32 +: 32] = $urandom;
      end
    end
    if (readyPat.size() > 0) bus.ireq_tready_in = (readyPat.pop_front() != 0);
    else if (holdReady)      bus.ireq_tready_in = 1'b1;
    else                     bus.ireq_tready_in = 1'($urandom_range(0, 1));

    #1;
    expValid = (mOwner >= 0) && bus.s_tvalid[mOwner];
    expReady = '0;
    if (mOwner >= 0) expReady[mOwner] = bus.ireq_tready_in;
    checkOutput("grant", 64'(grant_o), (mOwner >= 0) ? 64'(1) << mOwner : 64'd0);
    checkOutput("busy", 64'(busy_o), 64'(mOwner >= 0));
    checkOutput("overlong", 64'(overlong_o), 64'(mOvl));
    checkOutput("ireq_tvalid", 64'(bus.ireq_tvalid_o), 64'(expValid));
    checkOutput("s_tready", 64'(bus.s_tready), 64'(expReady));
    if (expValid) begin
      hb = portQ[mOwner][0];
      checkOutput("tdata", bus.ireq_tdata_o, hb.data);
      checkOutput("tkeep", 64'(bus.ireq_tkeep_o), 64'(hb.keep));
      checkOutput("tuser", 64'(bus.ireq_tuser_o), 64'(hb.user));
      checkOutput("tlast", 64'(bus.ireq_tlast_o), 64'(hb.last));
    end
    if (grant_o != '0 && prevGrant == '0) grantLog.push_back(grant_o);
    prevGrant = grant_o;
    if (overlong_o) ovlSeen++;
    if (bus.ireq_tvalid_o && bus.ireq_tready_in) beatsSeen++;

    if (log_rst) begin
      mOwner = -1;
      mPtr   = 0;
      mCnt   = 0;
      mOvl   = 1'b0;
      for (int p = 0; p < NUM_REQ; p++) portQ[p].delete();
    end else begin
      mOvl = 1'b0;
      if (mOwner < 0) begin
        mOwner = modelPick(bus.s_tvalid);
      end else if (bus.s_tvalid[mOwner] && bus.ireq_tready_in) begin
        hb = portQ[mOwner].pop_front();
        if (hb.last) begin
`ifdef SRIO_IREQ_ARB_DB_PRIO_EN
          if (mOwner != 0) mPtr = (mOwner + 1) % NUM_REQ;
`else
          mPtr = (mOwner + 1) % NUM_REQ;
`endif
          mOwner = -1;
          mCnt   = 0;
        end else begin
          if (mCnt == MAX_BEATS - 1) mOvl = 1'b1;
          if (mCnt < 63) mCnt++;
        end
      end
    end
  endtask

  task automatic runUntilIdle(input int maxCycles, input string tag);
    int n;
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!modelIdle() && n < maxCycles);
    checkOutput(tag, 64'(modelIdle()), 64'd1);
    applyStimulus();
  endtask

  task automatic doReset();
    rstReq = 1'b1;
    applyStimulus();
    applyStimulus();
    rstReq = 1'b0;
    grantLog.delete();
    ovlSeen   = 0;
    beatsSeen = 0;
    holdValid = 1'b1;
    holdReady = 1'b1;
  endtask

  initial begin
    logic [NUM_REQ-1:0] expOrder [4];
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    bus.s_tdata  = '0;
    bus.s_tkeep  = '0;
    bus.s_tuser  = '0;
    bus.ireq_tready_in = 1'b0;
    repeat (2) @(posedge log_clk);

    // Single doorbell, then a tie that shows where the pointer moved.
    doReset();
    enqueuePacket(0, 1, 1'b1, 64'h00A0_4000_0101_0000);
    runUntilIdle(20, "t1_drain");
    checkOutput("t1_grant_count", 64'(grantLog.size()), 64'd1);
    checkOutput("t1_first_grant", (grantLog.size() > 0) ? 64'(grantLog[0]) : 64'd0, 64'd1);
    grantLog.delete();
    enqueuePacket(0, 1, 1'b0, '0);
    enqueuePacket(1, 1, 1'b0, '0);
    runUntilIdle(20, "t1b_drain");
`ifdef SRIO_IREQ_ARB_DB_PRIO_EN
    checkOutput("t1b_ptr_grant", (grantLog.size() > 0) ? 64'(grantLog[0]) : 64'd0, 64'd1);
`else
    checkOutput("t1b_ptr_grant", (grantLog.size() > 0) ? 64'(grantLog[0]) : 64'd0, 64'd2);
`endif

    // Contention with both ports continuously valid.
    doReset();
    for (int i = 0; i < 2; i++) begin
      enqueuePacket(0, 3, 1'b0, '0);
      enqueuePacket(1, 3, 1'b0, '0);
    end
`ifdef SRIO_IREQ_ARB_DB_PRIO_EN
    expOrder = '{2'b01, 2'b01, 2'b10, 2'b10};
`else
    expOrder = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    runUntilIdle(60, "t2_drain");
    checkOutput("t2_grant_count", 64'(grantLog.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_order%0d", i),
                  (grantLog.size() > i) ? 64'(grantLog[i]) : 64'd0, 64'(expOrder[i]));
    end

    // Backpressure on a 4-beat port-1 packet.
    doReset();
    enqueuePacket(1, 4, 1'b0, '0);
    readyPat = '{1, 1, 0, 0, 1, 1, 0, 1};
    runUntilIdle(30, "t3_drain");
    checkOutput("t3_grant_count", 64'(grantLog.size()), 64'd1);
    checkOutput("t3_beats", 64'(beatsSeen), 64'd4);

    // Overlong 34-beat packet is flagged once and forwarded whole.
    doReset();
    enqueuePacket(0, 34, 1'b0, '0);
    runUntilIdle(60, "t4_drain");
    checkOutput("t4_overlong_pulses", 64'(ovlSeen), 64'd1);
    checkOutput("t4_beats", 64'(beatsSeen), 64'd34);

    // Reset on beat 2 of a 5-beat port-0 packet.
    doReset();
    enqueuePacket(0, 5, 1'b0, '0);
    applyStimulus();
    applyStimulus();
    rstReq = 1'b1;
    applyStimulus();
    rstReq = 1'b0;
    enqueuePacket(1, 2, 1'b0, '0);
    grantLog.delete();
    applyStimulus();
    checkOutput("t5_grant_after_rst", 64'(grant_o), 64'd0);
    checkOutput("t5_busy_after_rst", 64'(busy_o), 64'd0);
    checkOutput("t5_ready_after_rst", 64'(bus.s_tready), 64'd0);
    runUntilIdle(30, "t5_drain");
    checkOutput("t5_first_grant", (grantLog.size() > 0) ? 64'(grantLog[0]) : 64'd0, 64'd2);

    // Randomized traffic with valid gaps and random core ready.
    doReset();
    holdValid = 1'b0;
    holdReady = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 6; k++) begin
        enqueuePacket($urandom_range(0, NUM_REQ - 1),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(33, 36) : $urandom_range(1, 6),
                      1'b0, '0);
      end
      repeat (25) applyStimulus();
      for (int k = 0; k < 3; k++) begin
        enqueuePacket($urandom_range(0, NUM_REQ - 1), $urandom_range(1, 5), 1'b0, '0);
      end
      runUntilIdle(3000, $sformatf("t6_drain%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/srio_ireq_arbiter.md
Name: srio_ireq_arbiter

Overview:
- Packet-granular arbiter that shares the single SRIO logical-layer ireq AXI-Stream channel between NUM_REQ requesters, e.g. the doorbell/NWR requester, a maintenance requester and a future DMA engine.
- Sits between the requesters and the SRIO core ireq port.
- Grants one requester at a time, holds the grant until that packet's tlast handshake, then rotates round-robin.

Parameters:
- NUM_REQ, 2, number of requester ports; legal range 2..8.
- MAX_BEATS, 33, maximum legal beats per packet: one header plus 32 data beats (256 B).

Ports:
- log_clk  in  1  logical-layer clock
- log_rst  in  1  synchronous, active-high reset
- s_tvalid  in  NUM_REQ  per-requester valid
- s_tready  out  NUM_REQ  per-requester ready
- s_tlast  in  NUM_REQ  per-requester last
- s_tdata  in  64*NUM_REQ  per-requester data; requester i occupies bits [64i+63:64i]
- s_tkeep  in  8*NUM_REQ  per-requester keep
- s_tuser  in  32*NUM_REQ  per-requester {src_id, dest_id} user field
- ireq_tvalid_o  out  1  to core
- ireq_tready_in  in  1  from core
- ireq_tlast_o  out  1
- ireq_tdata_o  out  64
- ireq_tkeep_o  out  8
- ireq_tuser_o  out  32
- grant_o  out  NUM_REQ  one-hot current owner; 0 when idle
- busy_o  out  1  a packet is in flight
- overlong_o  out  1  one-cycle pulse when a packet exceeds MAX_BEATS

Behaviour:
- Clock and reset: one clock, log_clk. Reset log_rst is synchronous and active-high.
- Reset values: state=ARB_s, rr_ptr=0, beat_cnt=0, grant_o=0, busy_o=0, overlong_o=0.
- FSM states: ARB_s, XFER_s.
- ARB_s behaviour:
  - All s_tready=0 and ireq_tvalid_o=0.
  - If any s_tvalid is set, select the first asserted requester searching upward from rr_ptr with wrap-around.
  - Register its one-hot value in grant_o, set busy_o=1 and go to XFER_s.
  - Arbitration costs exactly 1 cycle: first beat on the output no earlier than 1 cycle after s_tvalid rises.
- XFER_s output path (combinational from the granted port, zero latency):
  - ireq_tvalid_o = s_tvalid[g]
  - s_tready[g] = ireq_tready_in
  - tdata, tkeep, tuser and tlast muxed from port g.
  - s_tready of every non-granted port is 0.
- XFER_s exit:
  - A beat transfers when ireq_tvalid_o && ireq_tready_in.
  - On a transfer with tlast: set rr_ptr=(g+1) mod NUM_REQ, grant_o=0, busy_o=0, beat_cnt=0, and return to ARB_s.
  - This leaves a mandatory 1-cycle bubble between packets.
- Grant lock:
  - The grant never changes mid-packet, even if the owner deasserts s_tvalid (bubbles pass through as ireq_tvalid_o=0).
  - Other requesters' tvalid is ignored while a grant is held.
- Beat counter:
  - beat_cnt, 6 bits, increments per transferred beat.
  - When a non-last beat transfers with beat_cnt==MAX_BEATS-1, pulse overlong_o for 1 cycle.
  - The packet is not truncated; beat_cnt saturates at 63.
- Fairness:
  - With all requesters continuously valid, grants cycle 0,1,..,NUM_REQ-1,0.
  - A requester waits at most NUM_REQ-1 packets.
- Simultaneous events: a new s_tvalid arriving on the same cycle as the owner's last beat is not considered until the next ARB_s cycle.
- Reset mid-packet: the FSM returns to ARB_s immediately, all s_tready=0, and the partial packet is abandoned. Requesters must restart after reset.

Optional Feature:
- Macro: SRIO_IREQ_ARB_DB_PRIO_EN.
- Defined: requester 0 (doorbell path) has strict priority in ARB_s. If s_tvalid[0]=1 it wins regardless of rr_ptr, and rr_ptr is not updated after a port-0 packet. The other ports remain round-robin among themselves.
- Undefined: pure round-robin as above.
- Packet locking is identical in both builds.

Decomposition:
- Shared package srio_pkg: ARB_s/XFER_s state encodings, constants IREQ_DATA_W=64, IREQ_KEEP_W=8, IREQ_USER_W=32, default MAX_BEATS=33, and the FTYPE constants DOORB=4'hA and NWR=4'h5 used by the benches.
- One sub-module: srio_rr_pick, a combinational rotate-priority picker with inputs req[NUM_REQ] and ptr and output a one-hot grant.

Test Plan:
- Single doorbell (NUM_REQ=2): s_tvalid[0]=1 with a 1-beat tlast packet, tdata=64'h00A0_4000_0101_0000, ready held high → grant_o=2'b01 one cycle later, one output beat with identical data and tuser, then grant_o=0 and rr_ptr=1.
- Contention: both ports hold 3-beat packets continuously → output order is port0, port1, port0, port1, with a 1-cycle idle between packets and no interleaving of beats.
- Backpressure: ireq_tready_in toggles 1,0,0,1 during a 4-beat port-1 packet → s_tready[1] mirrors it, no beat is lost or duplicated, and the grant is held throughout.
- Overlong: port 0 sends 34 beats with tlast on beat 34 → overlong_o pulses on the 33rd transfer; all 34 beats are forwarded.
- Reset mid-packet: log_rst asserted on beat 2 of 5 → next cycle grant_o=0, busy_o=0, s_tready=0; after release, the port-1 request is granted first because rr_ptr=0 and port 0 is idle.
- SRIO_IREQ_ARB_DB_PRIO_EN defined: ports 0 and 1 continuously valid → port 0 is granted every time and port 1 is starved; undefined build → alternates.
